// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Register-address width the match helper is built for
  localparam int REG_W = 5;

  // E-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW from writeback
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUOutM from memory stage

  // Architectural zero register: never a real dependency
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // True when source x depends on a writing producer with destination r
  function automatic logic match(input logic [REG_W-1:0] x,
                                 input logic [REG_W-1:0] r,
                                 input logic             we);
    return we && (x != REG_ZERO) && (x == r);
  endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// Shadow copy of the M and W destination controls. Advances with the
// pipeline and freezes while the data memory is in a wait state.
module hazard_dest_pipe
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mem_ready,
  input  logic                  i_reg_write_e,
  input  logic                  i_mem_to_reg_e,
  input  logic [REG_ADDR_W-1:0] i_write_reg_e,
  output logic                  o_reg_write_m,
  output logic                  o_mem_to_reg_m,
  output logic [REG_ADDR_W-1:0] o_write_reg_m,
  output logic                  o_reg_write_w,
  output logic [REG_ADDR_W-1:0] o_write_reg_w
);

  logic                  r_reg_write_m;
  logic                  r_mem_to_reg_m;
  logic [REG_ADDR_W-1:0] r_write_reg_m;
  logic                  r_reg_write_w;
  logic [REG_ADDR_W-1:0] r_write_reg_w;

  // Shift E->M->W on every edge the memory stage is not waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_write_reg_m  <= '0;
      r_reg_write_w  <= 1'b0;
      r_write_reg_w  <= '0;
    end else if (i_mem_ready) begin
      r_reg_write_m  <= i_reg_write_e;
      r_mem_to_reg_m <= i_mem_to_reg_e;
      r_write_reg_m  <= i_write_reg_e;
      r_reg_write_w  <= r_reg_write_m;
      r_write_reg_w  <= r_write_reg_m;
    end
  end

  assign o_reg_write_m  = r_reg_write_m;
  assign o_mem_to_reg_m = r_mem_to_reg_m;
  assign o_write_reg_m  = r_write_reg_m;
  assign o_reg_write_w  = r_reg_write_w;
  assign o_write_reg_w  = r_write_reg_w;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline:
// stall/flush generation, registered E-stage forward selects, D-stage
// branch forwards and a saturating stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic                  BranchD,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [CNT_W-1:0]      StallCount
);

  logic                  w_reg_write_m;
  logic                  w_mem_to_reg_m;
  logic [REG_ADDR_W-1:0] w_write_reg_m;
  logic                  w_reg_write_w;
  logic [REG_ADDR_W-1:0] w_write_reg_w;
  logic                  w_unused_w;

  hazard_dest_pipe #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_dest_pipe (
    .clk           (clk),
    .reset         (reset),
    .i_mem_ready   (MemReadyM),
    .i_reg_write_e (RegWriteE),
    .i_mem_to_reg_e(MemtoRegE),
    .i_write_reg_e (WriteRegE),
    .o_reg_write_m (w_reg_write_m),
    .o_mem_to_reg_m(w_mem_to_reg_m),
    .o_write_reg_m (w_write_reg_m),
    .o_reg_write_w (w_reg_write_w),
    .o_write_reg_w (w_write_reg_w)
  );

  // W-stage copies are kept for observability only; selects need E and M
  assign w_unused_w = &{1'b0, w_reg_write_w, w_write_reg_w};

  logic       w_rs_e, w_rt_e, w_rs_m, w_rt_m, w_rs_ml, w_rt_ml;
  logic       w_lwstall, w_brstall, w_memwait, w_dep_stall, w_stall_any;
  logic [1:0] w_fae_next, w_fbe_next;
  logic [1:0] r_fae, r_fbe;
  logic [CNT_W-1:0] r_count;

  // Dependency detection against the producers in E and M
  always_comb begin
    w_rs_e      = match(RsD, WriteRegE, RegWriteE);
    w_rt_e      = match(RtD, WriteRegE, RegWriteE);
    w_rs_m      = match(RsD, w_write_reg_m, w_reg_write_m);
    w_rt_m      = match(RtD, w_write_reg_m, w_reg_write_m);
    w_rs_ml     = match(RsD, w_write_reg_m, w_reg_write_m && w_mem_to_reg_m);
    w_rt_ml     = match(RtD, w_write_reg_m, w_reg_write_m && w_mem_to_reg_m);
    w_lwstall   = MemtoRegE && (w_rs_e || w_rt_e);
    w_brstall   = BranchD && (w_rs_e || w_rt_e || w_rs_ml || w_rt_ml);
    w_memwait   = !MemReadyM;
    w_dep_stall = w_lwstall || w_brstall;
    w_stall_any = w_dep_stall || w_memwait;
    // Youngest producer (E) wins over the older one (M)
    w_fae_next  = w_rs_e ? FWD_M : (w_rs_m ? FWD_W : FWD_RF);
    w_fbe_next  = w_rt_e ? FWD_M : (w_rt_m ? FWD_W : FWD_RF);
  end

  // Forward selects follow the D->E register: bubble on flush, hold on wait
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fae <= FWD_RF;
      r_fbe <= FWD_RF;
    end else if (MemReadyM) begin
      if (w_dep_stall) begin
        r_fae <= FWD_RF;
        r_fbe <= FWD_RF;
      end else begin
        r_fae <= w_fae_next;
        r_fbe <= w_fbe_next;
      end
    end
  end

  // Count stalled fetch cycles, sticking at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_stall_any && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Combinational controls are forced low for the whole reset pulse
  assign StallF     = !reset && w_stall_any;
  assign StallD     = !reset && w_stall_any;
  assign StallE     = !reset && w_memwait;
  assign StallM     = !reset && w_memwait;
  assign FlushE     = !reset && w_dep_stall && !w_memwait;
  assign ForwardAD  = !reset && w_rs_m;
  assign ForwardBD  = !reset && w_rt_m;
  assign ForwardAE  = r_fae;
  assign ForwardBE  = r_fbe;
  assign StallCount = r_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed, table-driven bench for hazard_unit. Each table row is one
// pipeline cycle: inputs, expected same-cycle controls, and expected
// registered values after the following clock edge.
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] RsD, RtD, WriteRegE;
  logic       BranchD, RegWriteE, MemtoRegE, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCount;

  // Narrow-counter instance to reach the saturation boundary quickly
  logic       s_sf, s_sd, s_se, s_sm, s_fe, s_ad, s_bd;
  logic [1:0] s_fae, s_fbe;
  logic [2:0] s_cnt;

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallCount(StallCount)
  );

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .MemReadyM(MemReadyM), .StallF(s_sf), .StallD(s_sd), .StallE(s_se),
    .StallM(s_sm), .FlushE(s_fe), .ForwardAE(s_fae), .ForwardBE(s_fbe),
    .ForwardAD(s_ad), .ForwardBD(s_bd), .StallCount(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       br, rwe, mte;
    logic [4:0] wre;
    logic       rdy;
    logic [6:0] comb;   // {StallF,StallD,StallE,StallM,FlushE,ForwardAD,ForwardBD}
    logic [1:0] fae, fbe;
    int         cnt;
  } vec_t;

  vec_t vecs[17];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic br, input logic rwe, input logic mte,
                              input logic [4:0] wre, input logic rdy,
                              input logic [6:0] comb, input logic [1:0] fae,
                              input logic [1:0] fbe, input int cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.br = br; v.rwe = rwe; v.mte = mte;
    v.wre = wre; v.rdy = rdy; v.comb = comb; v.fae = fae; v.fbe = fbe; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RsD = v.rs; RtD = v.rt; BranchD = v.br; RegWriteE = v.rwe;
    MemtoRegE = v.mte; WriteRegE = v.wre; MemReadyM = v.rdy;
  endtask

  function automatic logic [6:0] comb_now();
    return {StallF, StallD, StallE, StallM, FlushE, ForwardAD, ForwardBD};
  endfunction

  function automatic logic [6:0] comb_sat();
    return {s_sf, s_sd, s_se, s_sm, s_fe, s_ad, s_bd};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            rs rt br rwe mte wre rdy comb        fae    fbe    cnt
    vecs[0]  = mk(8, 0, 0, 1, 0, 8, 1, 7'b0000000, 2'b10, 2'b00, 0); // E producer -> 10
    vecs[1]  = mk(0, 8, 0, 0, 0, 0, 1, 7'b0000001, 2'b00, 2'b01, 0); // now in M -> 01
    vecs[2]  = mk(0, 9, 0, 1, 1, 9, 1, 7'b1100100, 2'b00, 2'b00, 1); // load-use stall
    vecs[3]  = mk(0, 9, 0, 0, 0, 0, 1, 7'b0000001, 2'b00, 2'b01, 1); // after bubble
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 1, 7'b0000000, 2'b00, 2'b00, 1); // $0 never stalls
    vecs[5]  = mk(5, 0, 0, 1, 0, 5, 1, 7'b0000000, 2'b10, 2'b00, 1); // set AE=10
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b1111000, 2'b10, 2'b00, 2); // mem wait 1
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b1111000, 2'b10, 2'b00, 3); // mem wait 2
    vecs[8]  = mk(0, 7, 0, 1, 1, 7, 0, 7'b1111000, 2'b10, 2'b00, 4); // wait beats load-use
    vecs[9]  = mk(0, 7, 0, 1, 1, 7, 1, 7'b1100100, 2'b00, 2'b00, 5); // load-use re-evaluated
    vecs[10] = mk(4, 0, 1, 1, 0, 4, 1, 7'b1100100, 2'b00, 2'b00, 6); // branch on E producer
    vecs[11] = mk(4, 0, 1, 0, 0, 0, 1, 7'b0000010, 2'b01, 2'b00, 6); // branch forward from M
    vecs[12] = mk(0, 3, 1, 1, 1, 3, 1, 7'b1100100, 2'b00, 2'b00, 7); // branch on load in E
    vecs[13] = mk(0, 3, 1, 0, 0, 0, 1, 7'b1100101, 2'b00, 2'b00, 8); // branch on load in M
    vecs[14] = mk(0, 3, 1, 0, 0, 0, 1, 7'b0000000, 2'b00, 2'b00, 8); // load gone, no stall
    vecs[15] = mk(0, 0, 0, 1, 0, 6, 1, 7'b0000000, 2'b00, 2'b00, 8); // put $6 writer in M
    vecs[16] = mk(6, 6, 0, 1, 0, 6, 1, 7'b0000011, 2'b10, 2'b10, 8); // E priority over M

    // Reset with a would-be stall on the inputs: everything must read 0
    reset = 1'b1;
    drive(mk(9, 9, 1, 1, 1, 9, 0, 7'b0, 2'b0, 2'b0, 0));
    #2;
    check("reset_comb", -1, {25'd0, comb_now()}, 32'd0);
    check("reset_fwd", -1, {28'd0, ForwardAE, ForwardBE}, 32'd0);
    check("reset_cnt", -1, StallCount, 32'd0);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 7'b0, 2'b0, 2'b0, 0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Table: drive just after an edge, check controls mid-cycle, then
    // check registered state just after the next edge
    for (int i = 0; i < 17; i++) begin
      int exp_sat;
      drive(vecs[i]);
      #3;
      check("comb", i, {25'd0, comb_now()}, {25'd0, vecs[i].comb});
      check("comb_sat", i, {25'd0, comb_sat()}, {25'd0, vecs[i].comb});
      @(posedge clk);
      #1;
      exp_sat = (vecs[i].cnt > 7) ? 7 : vecs[i].cnt;
      check("ForwardAE", i, {30'd0, ForwardAE}, {30'd0, vecs[i].fae});
      check("ForwardBE", i, {30'd0, ForwardBE}, {30'd0, vecs[i].fbe});
      check("StallCount", i, StallCount, vecs[i].cnt);
      check("StallCount_sat", i, {29'd0, s_cnt}, exp_sat);
      $display("[TB] step %0d rs=%0d rt=%0d br=%0b E(rw=%0b m2r=%0b wr=%0d) rdy=%0b -> ctl=%b AE=%b BE=%b cnt=%0d",
               i, vecs[i].rs, vecs[i].rt, vecs[i].br, vecs[i].rwe, vecs[i].mte,
               vecs[i].wre, vecs[i].rdy, comb_now(), ForwardAE, ForwardBE, StallCount);
    end

    // Reset mid-stall, between edges: outputs must clear without a clock
    drive(mk(6, 0, 0, 0, 0, 0, 0, 7'b0, 2'b0, 2'b0, 0));
    #3;
    check("midstall_pre", 100, {31'd0, StallF}, 32'd1);
    reset = 1'b1;
    #1;
    check("midstall_comb", 100, {25'd0, comb_now()}, 32'd0);
    check("midstall_fwd", 100, {28'd0, ForwardAE, ForwardBE}, 32'd0);
    check("midstall_cnt", 100, StallCount, 32'd0);
    check("midstall_cnt_sat", 100, {29'd0, s_cnt}, 32'd0);
    $display("[TB] async reset mid-stall -> ctl=%b AE=%b BE=%b cnt=%0d",
             comb_now(), ForwardAE, ForwardBE, StallCount);
    @(posedge clk);
    #1 reset = 1'b0;

    // First cycle after release sees an empty pipeline: no M forward
    drive(mk(6, 6, 1, 0, 0, 0, 1, 7'b0, 2'b0, 2'b0, 0));
    #3;
    check("post_reset_comb", 101, {25'd0, comb_now()}, 32'd0);
    @(posedge clk);
    #1;
    check("post_reset_fwd", 101, {28'd0, ForwardAE, ForwardBE}, 32'd0);
    check("post_reset_cnt", 101, StallCount, 32'd0);
    $display("[TB] first cycle after reset -> ctl=%b AE=%b BE=%b cnt=%0d",
             comb_now(), ForwardAE, ForwardBE, StallCount);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
